// File: rtl/can_rxq_axil.sv
// CAN receive queue with an AXI4-Lite register front end.
// Messages pushed by the CAN core land in a circular queue.
// Software reads the head entry through the register map and pops it by writing CTRL.
// A level interrupt fires on a fill threshold or on a sticky overflow.
module can_rxq_axil #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_DEPTH_LOG2       = 4,
    parameter int C_IRQ_THRESH_RST   = 1
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    // AXI4-Lite write address / data / response
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    // AXI4-Lite read address / data
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    // Message push interface from the CAN core
    input  logic                          MSG_VALID,
    input  logic [28:0]                   MSG_ID,
    input  logic                          MSG_IDE,
    input  logic                          MSG_RTR,
    input  logic [3:0]                    MSG_DLC,
    input  logic [63:0]                   MSG_DATA,
    // Status outputs
    output logic                          CAN_IRQ,
    output logic                          RXQ_FULL
);

    localparam int DEPTH = 1 << C_DEPTH_LOG2;

    // Entry layout: {data[63:0], dlc[3:0], rtr, ide, id[28:0]}
    localparam int ENTRY_W = 64 + 4 + 1 + 1 + 29;

    localparam logic [C_DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {C_DEPTH_LOG2{1'b0}}};

    // Register offsets decoded from address bits [4:2]
    localparam logic [2:0] REG_RXID    = 3'd0;
    localparam logic [2:0] REG_RXDLC   = 3'd1;
    localparam logic [2:0] REG_DATA_LO = 3'd2;
    localparam logic [2:0] REG_DATA_HI = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;
    localparam logic [2:0] REG_CTRL    = 3'd5;
    localparam logic [2:0] REG_THRESH  = 3'd6;
    localparam logic [2:0] REG_OVF_CNT = 3'd7;

    // Queue storage and bookkeeping
    logic [ENTRY_W-1:0]      mem [DEPTH];
    logic [C_DEPTH_LOG2-1:0] wr_ptr;
    logic [C_DEPTH_LOG2-1:0] rd_ptr;
    logic [C_DEPTH_LOG2:0]   count;
    logic                    empty;
    logic                    full;
    logic [15:0]             count16;

    // Overflow, threshold and interrupt state
    logic        ovf;
    logic [15:0] ovf_cnt;
    logic [15:0] irq_thresh;
    logic        irq;

    // AXI channel state
    logic        awready;
    logic        bvalid;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;

    // Decoded write-side controls
    logic       wr_fire;
    logic [2:0] wr_sel;
    logic       ctrl_wr;
    logic       pop_req;
    logic       pop_do;
    logic       ovf_clr;
    logic       flush;
    logic       push_do;
    logic       drop;

    // Head entry fields
    logic [ENTRY_W-1:0] head;
    logic [28:0]        head_id;
    logic               head_ide;
    logic               head_rtr;
    logic [3:0]         head_dlc;
    logic [63:0]        head_data;

    // Read side
    logic       ar_fire;
    logic [2:0] rd_sel;
    logic [31:0] rd_mux;
    logic [31:0] status_word;

    // Address bits outside [4:2] and the byte strobes carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WSTRB, S_AXI_WDATA};

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign count16 = 16'(count);

    // ------------------------------------------------------------------
    // Write-side decode: a register write takes effect in the handshake
    // cycle, i.e. while AWREADY is high together with both valids.
    // ------------------------------------------------------------------
    assign wr_fire = awready & S_AXI_AWVALID & S_AXI_WVALID;
    assign wr_sel  = S_AXI_AWADDR[4:2];
    assign ctrl_wr = wr_fire & (wr_sel == REG_CTRL);
    assign pop_req = ctrl_wr & S_AXI_WDATA[0];
    assign ovf_clr = ctrl_wr & S_AXI_WDATA[1];
    assign flush   = ctrl_wr & S_AXI_WDATA[2];

    // A pop on an empty queue is a no-op. A push is accepted whenever a
    // slot is free or the head leaves in the same cycle, so a full queue
    // with a concurrent pop never overflows. Flush discards both.
    assign pop_do  = pop_req & ~empty & ~flush;
    assign push_do = MSG_VALID & (~full | pop_do) & ~flush;
    assign drop    = MSG_VALID & full & ~pop_do & ~flush;

    // Queue RAM write port
    // NOTE: the RAM sits outside the reset domain on purpose; a reset would
    // stop it mapping onto memory primitives, and the empty flag already
    // masks whatever stale contents remain.
    always_ff @(posedge S_AXI_ACLK) begin
        if (push_do) begin
            mem[wr_ptr] <= {MSG_DATA, MSG_DLC, MSG_RTR, MSG_IDE, MSG_ID};
        end
    end

    // Pointer and occupancy update; flush overrides push and pop
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_do) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_do) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_do && !pop_do) begin
                count <= count + 1'b1;
            end else if (pop_do && !push_do) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky overflow flag and saturating drop counter; a clear wins
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (ovf_clr) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_cnt != 16'hFFFF) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
        end
    end

    // Interrupt threshold register
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            irq_thresh <= 16'(C_IRQ_THRESH_RST);
        end else if (wr_fire && wr_sel == REG_THRESH) begin
            irq_thresh <= S_AXI_WDATA[15:0];
        end
    end

    // Registered level interrupt; a zero threshold disables the fill term
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            irq <= 1'b0;
        end else begin
            irq <= ((irq_thresh != 16'd0) && (count16 >= irq_thresh)) || ovf;
        end
    end

    // Write channel: one-cycle AWREADY/WREADY pulse, then BVALID until BREADY
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            awready <= 1'b0;
            bvalid  <= 1'b0;
        end else begin
            awready <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid & ~awready;
            if (wr_fire) begin
                bvalid <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side: the head entry is read asynchronously from the RAM and
    // the selected register is captured into RDATA at acceptance.
    // ------------------------------------------------------------------
    assign head      = mem[rd_ptr];
    assign head_id   = head[28:0];
    assign head_ide  = head[29];
    assign head_rtr  = head[30];
    assign head_dlc  = head[34:31];
    assign head_data = head[98:35];

    assign status_word = {13'd0, ovf, full, empty, count16};
    assign ar_fire     = arready & S_AXI_ARVALID;
    assign rd_sel      = S_AXI_ARADDR[4:2];

    // Register read multiplexer; head-entry registers read 0 when empty
    // NOTE: every output of a combinational block gets a default first,
    // otherwise an unlisted path holds its old value and infers a latch.
    always_comb begin
        rd_mux = 32'd0;
        case (rd_sel)
            REG_RXID:    if (!empty) rd_mux = {head_ide, head_rtr, 1'b0, head_id};
            REG_RXDLC:   if (!empty) rd_mux = {28'd0, head_dlc};
            REG_DATA_LO: if (!empty) rd_mux = head_data[31:0];
            REG_DATA_HI: if (!empty) rd_mux = head_data[63:32];
            REG_STATUS:  rd_mux = status_word;
            REG_CTRL:    rd_mux = 32'd0;
            REG_THRESH:  rd_mux = {16'd0, irq_thresh};
            REG_OVF_CNT: rd_mux = {16'd0, ovf_cnt};
            default:     rd_mux = 32'd0;
        endcase
    end

    // Read channel: one-cycle ARREADY pulse, then RVALID/RDATA until RREADY
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            arready <= S_AXI_ARVALID & ~rvalid & ~arready;
            if (ar_fire) begin
                rvalid <= 1'b1;
                rdata  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = awready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign CAN_IRQ       = irq;
    assign RXQ_FULL      = full;

endmodule

// File: tb/tb_can_rxq_axil.sv
// Self-checking bench for can_rxq_axil: a scoreboard queue holds the
// messages expected at the head of the DUT queue, in push order.
module tb_can_rxq_axil;

    localparam int DEPTH = 16;
    localparam int TMO   = 50;

    typedef struct packed {
        logic [28:0] id;
        logic        ide;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
    } msg_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] aw_addr = '0;
    logic        aw_valid = 1'b0;
    logic        aw_ready;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = 4'hF;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready = 1'b1;
    logic [31:0] ar_addr = '0;
    logic        ar_valid = 1'b0;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
    logic        r_ready = 1'b1;
    logic        msg_valid = 1'b0;
    logic [28:0] msg_id = '0;
    logic        msg_ide = 1'b0;
    logic        msg_rtr = 1'b0;
    logic [3:0]  msg_dlc = '0;
    logic [63:0] msg_data = '0;
    logic        can_irq;
    logic        rxq_full;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard and overflow model
    msg_t sb[$];
    logic        m_ovf = 1'b0;
    logic [15:0] m_ovf_cnt = '0;

    can_rxq_axil dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .S_AXI_AWADDR (aw_addr),
        .S_AXI_AWVALID(aw_valid),
        .S_AXI_AWREADY(aw_ready),
        .S_AXI_WDATA  (w_data),
        .S_AXI_WSTRB  (w_strb),
        .S_AXI_WVALID (w_valid),
        .S_AXI_WREADY (w_ready),
        .S_AXI_BRESP  (b_resp),
        .S_AXI_BVALID (b_valid),
        .S_AXI_BREADY (b_ready),
        .S_AXI_ARADDR (ar_addr),
        .S_AXI_ARVALID(ar_valid),
        .S_AXI_ARREADY(ar_ready),
        .S_AXI_RDATA  (r_data),
        .S_AXI_RRESP  (r_resp),
        .S_AXI_RVALID (r_valid),
        .S_AXI_RREADY (r_ready),
        .MSG_VALID    (msg_valid),
        .MSG_ID       (msg_id),
        .MSG_IDE      (msg_ide),
        .MSG_RTR      (msg_rtr),
        .MSG_DLC      (msg_dlc),
        .MSG_DATA     (msg_data),
        .CAN_IRQ      (can_irq),
        .RXQ_FULL     (rxq_full)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_status();
        logic [15:0] cnt;
        cnt = 16'(sb.size());
        return {13'd0, m_ovf, (sb.size() == DEPTH), (sb.size() == 0), cnt};
    endfunction

    function automatic msg_t rand_msg();
        msg_t m;
        m.id   = 29'($urandom);
        m.ide  = 1'($urandom);
        m.rtr  = 1'($urandom);
        m.dlc  = 4'($urandom);
        m.data = {$urandom, $urandom};
        return m;
    endfunction

    task automatic drive_msg(input msg_t m);
        msg_id   = m.id;
        msg_ide  = m.ide;
        msg_rtr  = m.rtr;
        msg_dlc  = m.dlc;
        msg_data = m.data;
        msg_valid = 1'b1;
    endtask

    // One-cycle push strobe; the model accepts it only if a slot is free
    task automatic push_msg(input msg_t m);
        @(negedge clk);
        drive_msg(m);
        @(negedge clk);
        msg_valid = 1'b0;
        if (sb.size() < DEPTH) begin
            sb.push_back(m);
        end else begin
            m_ovf = 1'b1;
            if (m_ovf_cnt != 16'hFFFF) m_ovf_cnt++;
        end
    endtask

    // AXI write; optionally strobes MSG_VALID in the handshake cycle
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input bit with_push, input msg_t m);
        int t;
        @(negedge clk);
        aw_addr = 32'(addr);
        w_data = data;
        aw_valid = 1'b1;
        w_valid = 1'b1;
        b_ready = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!aw_ready && t < TMO);
        n_tests++;
        if (aw_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL aw_timeout addr=%0h: awready=%b, expected 1", addr, aw_ready);
        end
        if (with_push) drive_msg(m);
        @(negedge clk);
        aw_valid = 1'b0;
        w_valid = 1'b0;
        msg_valid = 1'b0;
        t = 0;
        while (!b_valid && t < TMO) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (b_valid !== 1'b1 || b_resp !== 2'b00) begin
            n_fail++;
            $display("FAIL bresp addr=%0h: bvalid=%b bresp=%b, expected 1/00", addr, b_valid, b_resp);
        end
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data);
        int t;
        @(negedge clk);
        ar_addr = 32'(addr);
        ar_valid = 1'b1;
        r_ready = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ar_ready && t < TMO);
        @(negedge clk);
        ar_valid = 1'b0;
        t = 0;
        while (!r_valid && t < TMO) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (r_valid !== 1'b1 || r_resp !== 2'b00) begin
            n_fail++;
            $display("FAIL read_timeout addr=%0h: rvalid=%b rresp=%b, expected 1/00", addr, r_valid, r_resp);
        end
        data = r_data;
        @(negedge clk);
    endtask

    task automatic read_expect(input string name, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] got;
        axi_read(addr, got);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, got, exp);
        end
    endtask

    // Checks the four head registers against the scoreboard, then pops
    task automatic pop_and_check(input string name);
        msg_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, expected an entry", name);
            return;
        end
        e = sb.pop_front();
        read_expect({name, "_rxid"}, 8'h00, {e.ide, e.rtr, 1'b0, e.id});
        read_expect({name, "_dlc"},  8'h04, {28'd0, e.dlc});
        read_expect({name, "_dlo"},  8'h08, e.data[31:0]);
        read_expect({name, "_dhi"},  8'h0C, e.data[63:32]);
        axi_write(8'h14, 32'h1, 1'b0, '0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({aw_ready, w_ready, b_valid, ar_ready, r_valid, can_irq, rxq_full} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 0000000",
                     {aw_ready, w_ready, b_valid, ar_ready, r_valid, can_irq, rxq_full});
        end
        read_expect("reset_status", 8'h10, 32'h0001_0000);
        read_expect("reset_thresh", 8'h18, 32'd1);
        read_expect("reset_ovfcnt", 8'h1C, 32'd0);
        read_expect("reset_rxid_empty", 8'h00, 32'd0);
    endtask

    task automatic test_basic();
        msg_t m;
        m.id = 29'h1ABCDEF; m.ide = 1'b1; m.rtr = 1'b0; m.dlc = 4'd8;
        m.data = 64'h0123_4567_89AB_CDEF;
        push_msg(m);
        read_expect("basic_rxid",   8'h00, 32'h81AB_CDEF);
        read_expect("basic_dlc",    8'h04, 32'h0000_0008);
        read_expect("basic_dlo",    8'h08, 32'h89AB_CDEF);
        read_expect("basic_dhi",    8'h0C, 32'h0123_4567);
        read_expect("basic_status", 8'h10, 32'h0000_0001);
        read_expect("basic_ctrl_rd0", 8'h14, 32'd0);
        n_tests++;
        if (can_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_irq: got %b, expected 1", can_irq);
        end
        void'(sb.pop_front());
        axi_write(8'h14, 32'h1, 1'b0, '0);
        read_expect("basic_status_after_pop", 8'h10, exp_status());
    endtask

    task automatic test_empty_pop();
        axi_write(8'h14, 32'h1, 1'b0, '0);
        read_expect("empty_pop_status", 8'h10, exp_status());
        push_msg(rand_msg());
        read_expect("empty_pop_then_push_status", 8'h10, exp_status());
        pop_and_check("empty_pop_head");
        read_expect("empty_pop_final", 8'h10, exp_status());
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 1; i++) push_msg(rand_msg());
        read_expect("ovf_status", 8'h10, exp_status());
        read_expect("ovf_status_lit", 8'h10, 32'h0006_0010);
        read_expect("ovf_cnt", 8'h1C, {16'd0, m_ovf_cnt});
        n_tests++;
        if (can_irq !== 1'b1 || rxq_full !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_irq_full: got irq=%b full=%b, expected 1/1", can_irq, rxq_full);
        end
        axi_write(8'h14, 32'h2, 1'b0, '0);
        m_ovf = 1'b0;
        m_ovf_cnt = '0;
        read_expect("ovf_clr_status", 8'h10, 32'h0002_0010);
        read_expect("ovf_clr_cnt", 8'h1C, 32'd0);
    endtask

    // Queue is full on entry: push in the same cycle as a CTRL pop
    task automatic test_push_pop_full();
        msg_t m;
        m = rand_msg();
        axi_write(8'h14, 32'h1, 1'b1, m);
        void'(sb.pop_front());
        sb.push_back(m);
        read_expect("ppf_status", 8'h10, exp_status());
        read_expect("ppf_ovfcnt", 8'h1C, 32'd0);
        for (int i = 0; i < DEPTH; i++) pop_and_check($sformatf("ppf_pop%0d", i));
        read_expect("ppf_drained", 8'h10, 32'h0001_0000);
    endtask

    task automatic test_irq_thresh();
        axi_write(8'h18, 32'd3, 1'b0, '0);
        read_expect("irq_thresh_rd", 8'h18, 32'd3);
        push_msg(rand_msg());
        push_msg(rand_msg());
        @(negedge clk);
        n_tests++;
        if (can_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_two: got %b, expected 0", can_irq);
        end
        push_msg(rand_msg());
        n_tests++;
        if (can_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_third_same_cycle: got %b, expected 0", can_irq);
        end
        @(negedge clk);
        n_tests++;
        if (can_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_third_next_cycle: got %b, expected 1", can_irq);
        end
        pop_and_check("irq_pop");
        @(negedge clk);
        n_tests++;
        if (can_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_after_pop: got %b, expected 0", can_irq);
        end
        axi_write(8'h14, 32'h4, 1'b0, '0);
        sb.delete();
        read_expect("irq_flush_status", 8'h10, exp_status());
    endtask

    task automatic test_back_to_back_bstall();
        int t;
        @(negedge clk);
        aw_addr = 32'h18;
        w_data = 32'd5;
        aw_valid = 1'b1;
        w_valid = 1'b1;
        b_ready = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!aw_ready && t < TMO);
        @(negedge clk);
        w_data = 32'd7;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (b_valid !== 1'b1 || aw_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bstall_hold%0d: bvalid=%b awready=%b, expected 1/0", i, b_valid, aw_ready);
            end
            @(negedge clk);
        end
        b_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (b_valid !== 1'b0 || aw_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bstall_release: bvalid=%b awready=%b, expected 0/0", b_valid, aw_ready);
        end
        @(negedge clk);
        n_tests++;
        if (aw_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bstall_second_accept: awready=%b, expected 1", aw_ready);
        end
        @(negedge clk);
        aw_valid = 1'b0;
        w_valid = 1'b0;
        t = 0;
        while (!b_valid && t < TMO) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        read_expect("bstall_thresh", 8'h18, 32'd7);
    endtask

    task automatic test_reset_mid_read();
        int t;
        for (int i = 0; i < 4; i++) push_msg(rand_msg());
        read_expect("rmr_status_before", 8'h10, exp_status());
        @(negedge clk);
        ar_addr = 32'h10;
        ar_valid = 1'b1;
        r_ready = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ar_ready && t < TMO);
        @(negedge clk);
        ar_valid = 1'b0;
        n_tests++;
        if (r_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rmr_rvalid_before: got %b, expected 1", r_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (r_valid !== 1'b0 || r_data !== 32'd0 || can_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL rmr_async_clear: rvalid=%b rdata=%08h irq=%b, expected 0/0/0", r_valid, r_data, can_irq);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
        m_ovf_cnt = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (r_valid !== 1'b0 || b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmr_no_response: rvalid=%b bvalid=%b, expected 0/0", r_valid, b_valid);
        end
        read_expect("rmr_status_after", 8'h10, 32'h0001_0000);
        read_expect("rmr_thresh_after", 8'h18, 32'd1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_pop();
        test_overflow();
        test_push_pop_full();
        test_irq_thresh();
        test_back_to_back_bstall();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
